// File: rtl/pid_pwm_out.sv
// PWM output stage: turns the signed PID current command into a complementary,
// dead-time protected gate-drive pair with period-aligned duty updates.
module pid_pwm_out #(
   parameter int unsigned CNT_W  = 16,
   parameter int unsigned PERIOD = 2500,
   parameter int unsigned DEAD   = 25
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      i_current,
   input  logic             cmd_valid,
   input  logic             enable,
   output logic             pwm_h,
   output logic             pwm_l,
   output logic             dir,
   output logic             period_start,
   output logic             sat,
   output logic [CNT_W-1:0] duty_active
);

   localparam int unsigned MAX_DUTY = PERIOD - 2 * DEAD;
   localparam int unsigned DCNT_W   = $clog2(DEAD + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PERIOD - 1);
   localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEAD - 1);

   typedef enum logic [2:0] {
      S_OFF   = 3'd0,
      S_L     = 3'd1,
      S_DT_LH = 3'd2,
      S_H     = 3'd3,
      S_DT_HL = 3'd4
   } state_t;

   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [31:0]       shadow_q;
   logic [CNT_W-1:0]  duty_q, duty_d;
   logic              dir_q, sat_q, sat_d, raw_q, ps_q;
   logic              pwm_h_q, pwm_l_q;
   logic [31:0]       mag_c;
   state_t            state_q, state_d;
   logic [DCNT_W-1:0] dcnt_q, dcnt_d;
   logic              last_c;

   assign last_c = (cnt_q == CNT_LAST);
   assign cnt_d  = last_c ? '0 : cnt_q + CNT_W'(1);

   // Two's-complement magnitude; 0x80000000 maps to 2^31 as an unsigned value.
   assign mag_c  = shadow_q[31] ? (~shadow_q + 32'd1) : shadow_q;
   assign sat_d  = (mag_c > MAX_DUTY);
   assign duty_d = sat_d ? CNT_W'(MAX_DUTY) : mag_c[CNT_W-1:0];

   // Period counter, command shadow, period-boundary duty load and raw compare.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q    <= '0;
         shadow_q <= '0;
         duty_q   <= '0;
         dir_q    <= 1'b0;
         sat_q    <= 1'b0;
         raw_q    <= 1'b0;
         ps_q     <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         ps_q  <= last_c;
         raw_q <= (cnt_q < duty_q);
         if (cmd_valid) shadow_q <= i_current;
         if (last_c) begin
            dir_q  <= shadow_q[31];
            duty_q <= duty_d;
            sat_q  <= sat_d;
         end
      end
   end

   // Dead-time state register; gate outputs are registered copies of the next state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_OFF;
         dcnt_q  <= '0;
         pwm_h_q <= 1'b0;
         pwm_l_q <= 1'b0;
      end else begin
         state_q <= state_d;
         dcnt_q  <= dcnt_d;
         pwm_h_q <= (state_d == S_H);
         pwm_l_q <= (state_d == S_L);
      end
   end

   always_comb begin
      state_d = state_q;
      dcnt_d  = '0;
      unique case (state_q)
         S_OFF:   if (enable) state_d = raw_q ? S_DT_LH : S_DT_HL;
         S_L:     if (raw_q) state_d = S_DT_LH;
         S_H:     if (!raw_q) state_d = S_DT_HL;
         S_DT_LH: begin
            if (!raw_q)                  state_d = S_L;
            else if (dcnt_q == DCNT_LAST) state_d = S_H;
            else                         dcnt_d  = dcnt_q + DCNT_W'(1);
         end
         S_DT_HL: begin
            if (raw_q)                   state_d = S_H;
            else if (dcnt_q == DCNT_LAST) state_d = S_L;
            else                         dcnt_d  = dcnt_q + DCNT_W'(1);
         end
         default: state_d = S_OFF;
      endcase
      if (!enable) begin
         state_d = S_OFF;
         dcnt_d  = '0;
      end
   end

   assign pwm_h        = pwm_h_q;
   assign pwm_l        = pwm_l_q;
   assign dir          = dir_q;
   assign period_start = ps_q;
   assign sat          = sat_q;
   assign duty_active  = duty_q;

endmodule

// File: tb/tb_pid_pwm_out.sv
// Directed bench for pid_pwm_out: duty load, saturation, dead time, enable and reset.
module tb_pid_pwm_out;

   localparam int PERIOD = 2500;
   localparam int DEAD   = 25;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] i_current;
   logic        cmd_valid;
   logic        enable;
   logic        pwm_h, pwm_l, dir, period_start, sat;
   logic [15:0] duty_active;

   int passes = 0;
   int checks = 0;
   int overlap_cnt = 0;
   int handover_err = 0;
   int last_side = 0;
   int zrun = 0;

   pid_pwm_out #(.CNT_W(16), .PERIOD(PERIOD), .DEAD(DEAD)) dut (
      .clk          (clk),
      .rst          (rst),
      .i_current    (i_current),
      .cmd_valid    (cmd_valid),
      .enable       (enable),
      .pwm_h        (pwm_h),
      .pwm_l        (pwm_l),
      .dir          (dir),
      .period_start (period_start),
      .sat          (sat),
      .duty_active  (duty_active)
   );

   always #5 clk = ~clk;

   // Watch for shoot-through and for H/L handovers shorter than the dead time.
   always @(negedge clk) begin
      if (rst) begin
         last_side <= 0;
         zrun      <= 0;
      end else begin
         if (pwm_h && pwm_l) overlap_cnt <= overlap_cnt + 1;
         if (pwm_h || pwm_l) begin
            if (last_side != 0 && last_side != (pwm_h ? 1 : 2) && zrun < DEAD)
               handover_err <= handover_err + 1;
            last_side <= pwm_h ? 1 : 2;
            zrun      <= 0;
         end else begin
            zrun <= zrun + 1;
         end
      end
   end

   task automatic chk(input string tag, input longint obs, input longint exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic write_cmd(input logic [31:0] v);
      i_current = v;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_ps();
      int n = 0;
      @(negedge clk);
      while (period_start !== 1'b1 && n < 3 * PERIOD) begin
         @(negedge clk);
         n++;
      end
      chk("period_start_seen", longint'(period_start), 1);
   endtask

   task automatic measure(output int h, output int l, output int z);
      h = 0; l = 0; z = 0;
      for (int i = 0; i < PERIOD; i++) begin
         if (pwm_h) h++;
         if (pwm_l) l++;
         if (!pwm_h && !pwm_l) z++;
         @(negedge clk);
      end
   endtask

   task automatic run_case(input string tag, input logic [31:0] v,
                           input int e_duty, input int e_dir, input int e_sat,
                           input int e_h, input int e_l, input int e_z);
      int h, l, z;
      write_cmd(v);
      wait_ps();
      chk({tag, "_duty"}, longint'(duty_active), e_duty);
      chk({tag, "_dir"},  longint'(dir), e_dir);
      chk({tag, "_sat"},  longint'(sat), e_sat);
      measure(h, l, z);
      chk({tag, "_h_cycles"}, h, e_h);
      chk({tag, "_l_cycles"}, l, e_l);
      chk({tag, "_both_low"}, z, e_z);
   endtask

   initial begin
      int h, l, z, n, l25, l26, h_seen;
      rst = 1'b1; enable = 1'b0; cmd_valid = 1'b0; i_current = '0;
      step(3);
      chk("rst_pwm_h", longint'(pwm_h), 0);
      chk("rst_pwm_l", longint'(pwm_l), 0);
      chk("rst_dir", longint'(dir), 0);
      chk("rst_sat", longint'(sat), 0);
      chk("rst_duty", longint'(duty_active), 0);
      chk("rst_period_start", longint'(period_start), 0);
      rst = 1'b0;
      enable = 1'b1;

      run_case("d1000", 32'd1000, 1000, 0, 0, 975, 1475, 50);
      run_case("dneg2517", 32'hFFFF_F62B, 2450, 1, 1, 2425, 25, 50);
      run_case("dmin", 32'h8000_0000, 2450, 1, 1, 2425, 25, 50);
      run_case("dzero", 32'd0, 0, 0, 0, 0, 2500, 0);

      // Two writes in one period: last one wins, current period untouched.
      step(400);
      write_cmd(32'd300);
      step(499);
      write_cmd(32'd700);
      chk("dbl_cur_duty", longint'(duty_active), 0);
      chk("dbl_cur_pwm_l", longint'(pwm_l), 1);
      wait_ps();
      chk("dbl_next_duty", longint'(duty_active), 700);
      measure(h, l, z);
      chk("dbl_h_cycles", h, 675);
      chk("dbl_l_cycles", l, 1775);
      chk("dbl_both_low", z, 50);

      run_case("d10", 32'd10, 10, 0, 0, 0, 2490, 10);

      // Enable drop mid-pulse, then re-enable with raw high.
      write_cmd(32'd1000);
      wait_ps();
      chk("en_duty", longint'(duty_active), 1000);
      step(500);
      chk("en_pre_h", longint'(pwm_h), 1);
      enable = 1'b0;
      step(1);
      chk("en_off_h", longint'(pwm_h), 0);
      chk("en_off_l", longint'(pwm_l), 0);
      step(9);
      enable = 1'b1;
      z = 0;
      step(1);
      while (!pwm_h && !pwm_l && z < 100) begin
         z++;
         step(1);
      end
      chk("en_on_dead_cycles", z, DEAD);
      chk("en_on_h", longint'(pwm_h), 1);
      chk("en_on_l", longint'(pwm_l), 0);

      // Asynchronous reset mid-period while the high side is on.
      write_cmd(32'd2000);
      wait_ps();
      step(1200);
      chk("ar_pre_h", longint'(pwm_h), 1);
      #2 rst = 1'b1;
      #1;
      chk("ar_pwm_h", longint'(pwm_h), 0);
      chk("ar_pwm_l", longint'(pwm_l), 0);
      chk("ar_dir", longint'(dir), 0);
      chk("ar_sat", longint'(sat), 0);
      chk("ar_duty", longint'(duty_active), 0);
      step(2);
      rst = 1'b0;
      n = 0; l25 = -1; l26 = -1; h_seen = 0;
      while (n < 3 * PERIOD) begin
         step(1);
         n++;
         if (n == 1) chk("ar_rel_l", longint'(pwm_l), 0);
         if (n == 25) l25 = int'(pwm_l);
         if (n == 26) l26 = int'(pwm_l);
         if (pwm_h) h_seen++;
         if (period_start) break;
      end
      chk("ar_period_len", n, PERIOD);
      chk("ar_l_at_25", l25, 0);
      chk("ar_l_at_26", l26, 1);
      chk("ar_h_seen", h_seen, 0);
      chk("ar_duty_after", longint'(duty_active), 0);

      chk("overlap_cycles", overlap_cnt, 0);
      chk("short_handovers", handover_err, 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
